// File: rtl/wb_arb_if.sv
// Writeback arbiter bus: requester handshakes plus the register-file write port and FIFO pop.
// master is the arbiter side, slave is the surrounding pipeline.
interface wb_arb_if #(
    parameter int NREQ = 2,
    parameter int XLEN = 64,
    parameter int RAW  = 5
);
    logic [NREQ-1:0]      req_vld;
    logic [NREQ*RAW-1:0]  req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_rdy;
    logic                 flush_witf;
    logic                 witf_empty;
    logic                 wb_vld;
    logic [RAW-1:0]       wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic                 wb_en;
    logic                 err;

    modport master (
        input  req_vld, req_rd, req_data, flush_witf, witf_empty,
        output req_rdy, wb_vld, wb_rd, wb_data, wb_en, err
    );

    modport slave (
        output req_vld, req_rd, req_data, flush_witf, witf_empty,
        input  req_rdy, wb_vld, wb_rd, wb_data, wb_en, err
    );
endinterface

// File: rtl/wb_arb.sv
// Round-robin writeback arbiter with one registered output stage and flush masking.
// Define WB_ARB_PERF_EN to add saturating grant/conflict performance counters.
module wb_arb #(
    parameter int NREQ = 2,
    parameter int XLEN = 64,
    parameter int RAW  = 5
) (
    input  logic        clk,
    input  logic        rst,
    wb_arb_if.master    bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0] perf_grant_cnt,
    output logic [31:0] perf_conflict_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   ptr_q, ptr_d;
    logic            outVld_q, outVld_d;
    logic [RAW-1:0]  rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;

    logic            found;
    logic [IW-1:0]   grantIdx;
    logic            handshake;

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        found    = 1'b0;
        grantIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_vld[(int'(ptr_q) + k) % NREQ]) begin
                found    = 1'b1;
                grantIdx = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign handshake   = found & ~bus.flush_witf;
    assign bus.req_rdy = handshake ? (NREQ'(1) << grantIdx) : '0;

    always_comb begin
        ptr_d    = ptr_q;
        outVld_d = handshake;
        rd_d     = rd_q;
        data_d   = data_q;
        err_d    = err_q;
        if (handshake) begin
            ptr_d  = (grantIdx == IW'(NREQ - 1)) ? '0 : grantIdx + IW'(1);
            rd_d   = bus.req_rd[int'(grantIdx)*RAW +: RAW];
            data_d = bus.req_data[int'(grantIdx)*XLEN +: XLEN];
            if (bus.witf_empty && !outVld_q) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= '0;
            outVld_q <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            outVld_q <= outVld_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // Flush masks the pop and the write in the same cycle; x0 is popped but never written.
    assign bus.wb_en   = outVld_q & ~bus.flush_witf;
    assign bus.wb_vld  = outVld_q & ~bus.flush_witf & (rd_q != '0);
    assign bus.wb_rd   = rd_q;
    assign bus.wb_data = data_q;
    assign bus.err     = err_q;

`ifdef WB_ARB_PERF_EN
    logic [31:0] grantCnt_q, conflictCnt_q;
    logic        conflict;

    assign conflict = ($countones(bus.req_vld) >= 2) && !bus.flush_witf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grantCnt_q    <= '0;
            conflictCnt_q <= '0;
        end else begin
            if (handshake && (grantCnt_q != '1)) begin
                grantCnt_q <= grantCnt_q + 32'd1;
            end
            if (conflict && (conflictCnt_q != '1)) begin
                conflictCnt_q <= conflictCnt_q + 32'd1;
            end
        end
    end

    assign perf_grant_cnt    = grantCnt_q;
    assign perf_conflict_cnt = conflictCnt_q;
`endif

endmodule
